idx_mask_builder: RTL



---
 rtl/idx_mask_pkg.sv | 18 +
 rtl/idx_mask_dec.sv | 25 ++
 rtl/idx_mask_builder.sv | 89 ++++++++
 3 files changed

// File: rtl/idx_mask_pkg.sv
// Shared types and index helpers for the index-to-mask rebuilder.
package idx_mask_pkg;

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } state_t;

  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // MODE 1 counts from the MSB; the mapping is its own inverse.
  function automatic int idx_to_bit(input int idx, input int width, input int mode);
    return (mode == 1) ? (width - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/idx_mask_dec.sv
// Combinational index-to-one-hot decoder with in-range flag; zero latency, no flow control.
module idx_mask_dec
  import idx_mask_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MODE  = 0,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic [IDX_W-1:0] i_idx,
  output logic [WIDTH-1:0] o_onehot,
  output logic             o_in_range
);

  // Walk bit positions and ask which index lands there, so no index ever
  // addresses past the vector for non-power-of-2 widths.
  always_comb begin
    o_onehot = '0;
    for (int b = 0; b < WIDTH; b++) begin
      o_onehot[b] = (i_idx == IDX_W'(idx_to_bit(b, WIDTH, MODE)));
    end
  end

  assign o_in_range = |o_onehot;

endmodule

// File: rtl/idx_mask_builder.sv
// Rebuilds a WIDTH-bit mask from index beats until last; mask valid the cycle after the last beat,
// beats stalled while the mask waits for ready. Macro IDX_MASK_BUILDER_DUP_CHECK_EN flags duplicate indices.
module idx_mask_builder
  import idx_mask_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int MODE     = 0,
  localparam int IdxWidth = idx_width(WIDTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                idx_valid_i,
  output logic                idx_ready_o,
  input  logic [IdxWidth-1:0] idx_i,
  input  logic                idx_empty_i,
  input  logic                idx_last_i,
  output logic                mask_valid_o,
  input  logic                mask_ready_i,
  output logic [WIDTH-1:0]    mask_o,
  output logic                err_o
);

  state_t           r_state;
  logic [WIDTH-1:0] r_mask;
  logic             r_err;

  logic [WIDTH-1:0] w_onehot;
  logic             w_in_range;
  logic             w_accept;
  logic             w_hit;
  logic             w_dup;

  idx_mask_dec #(
    .WIDTH(WIDTH),
    .MODE (MODE),
    .IDX_W(IdxWidth)
  ) u_dec (
    .i_idx     (idx_i),
    .o_onehot  (w_onehot),
    .o_in_range(w_in_range)
  );

  assign idx_ready_o  = (r_state == ACCUM);
  assign mask_valid_o = (r_state == OUTPUT);
  assign mask_o       = mask_valid_o ? r_mask : '0;
  assign err_o        = mask_valid_o & r_err;

  // clear wins over the beat handshake even though ready still reads high
  assign w_accept = idx_valid_i & idx_ready_o & ~clear_i;
  assign w_hit    = w_accept & ~idx_empty_i;

`ifdef IDX_MASK_BUILDER_DUP_CHECK_EN
  assign w_dup = w_hit & w_in_range & (|(r_mask & w_onehot));
`else
  assign w_dup = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ACCUM;
      r_mask  <= '0;
      r_err   <= 1'b0;
    end else if (clear_i) begin
      r_state <= ACCUM;
      r_mask  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_hit) begin
            r_mask <= r_mask | w_onehot;
            if (!w_in_range || w_dup) r_err <= 1'b1;
          end
          if (w_accept && idx_last_i) r_state <= OUTPUT;
        end
        OUTPUT: begin
          if (mask_ready_i) begin
            r_state <= ACCUM;
            r_mask  <= '0;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule
